// File: rtl/space_monsters_pkg.sv
// Shared game-state codes and active-low seven-segment glyph constants.
package space_monsters_pkg;

  localparam logic [6:0] START   = 7'b0000001;
  localparam logic [6:0] L1I     = 7'b0000010;
  localparam logic [6:0] L1      = 7'b0000100;
  localparam logic [6:0] L2I     = 7'b0001000;
  localparam logic [6:0] L2      = 7'b0010000;
  localparam logic [6:0] SUCCESS = 7'b0100000;
  localparam logic [6:0] FAILED  = 7'b1000000;

  // Segments {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Glyph codes 0..15 are hex digits; letters F/E reuse their hex codes.
  localparam logic [4:0] GLY_E     = 5'd14;
  localparam logic [4:0] GLY_F     = 5'd15;
  localparam logic [4:0] GLY_DASH  = 5'd16;
  localparam logic [4:0] GLY_P     = 5'd17;
  localparam logic [4:0] GLY_S     = 5'd18;
  localparam logic [4:0] GLY_BLANK = 5'd19;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational glyph-code to active-low seven-segment decoder.
module seg7_decoder
  import space_monsters_pkg::*;
(
  input  logic [4:0] i_glyph,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_glyph[4]) begin
      o_seg = SEG_HEX[i_glyph[3:0]];
    end else begin
      case (i_glyph)
        GLY_DASH: o_seg = SEG_DASH;
        GLY_P:    o_seg = SEG_P;
        GLY_S:    o_seg = SEG_S;
        default:  o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display_driver.sv
// Four-digit multiplexed display of score, level, session high score and game status,
// blinking the whole display in the end states.
module score_display_driver
  import space_monsters_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 18,
  parameter int unsigned BLINK_BITS   = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] score,
  input  logic [6:0] state,
  output logic [3:0] an,
  output logic [6:0] ssd,
  output logic       dp
);

  logic [6:0]              r_state;
  logic [6:0]              r_state_prev;
  logic [3:0]              r_score;
  logic [3:0]              r_high_score;
  logic [REFRESH_BITS-1:0] r_scan_cnt;
  logic [BLINK_BITS-1:0]   r_blink_cnt;
  logic [3:0]              r_an;
  logic [6:0]              r_ssd;
  logic                    r_dp;

  logic [1:0] w_idx;
  logic       w_end;
  logic       w_end_entry;
  logic       w_hs_live;
  logic       w_blank;
  logic [4:0] w_level;
  logic [4:0] w_status;
  logic [4:0] w_glyph;
  logic [6:0] w_seg;

  assign w_idx       = r_scan_cnt[REFRESH_BITS-1 -: 2];
  assign w_end       = (r_state == SUCCESS) || (r_state == FAILED);
  // Any change into an end state, including SUCCESS<->FAILED, restarts the blink period.
  assign w_end_entry = w_end && (r_state != r_state_prev);
  assign w_hs_live   = (r_state == L1) || (r_state == L2) || w_end;
  assign w_blank     = w_end && r_blink_cnt[BLINK_BITS-1];

  always_comb begin
    w_level = GLY_DASH;
    case (r_state)
      L1I, L1:          w_level = 5'd1;
      L2I, L2, SUCCESS: w_level = 5'd2;
      default:          w_level = GLY_DASH;
    endcase
  end

  always_comb begin
    w_status = GLY_E;
    case (r_state)
      START:            w_status = GLY_BLANK;
      L1I, L1, L2I, L2: w_status = GLY_P;
      SUCCESS:          w_status = GLY_S;
      FAILED:           w_status = GLY_F;
      default:          w_status = GLY_E;
    endcase
  end

  always_comb begin
    w_glyph = GLY_BLANK;
    case (w_idx)
      2'd0:    w_glyph = {1'b0, r_score};
      2'd1:    w_glyph = w_level;
      2'd2:    w_glyph = {1'b0, r_high_score};
      default: w_glyph = w_status;
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .i_glyph (w_glyph),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= START;
      r_state_prev <= START;
      r_score      <= 4'd0;
      r_high_score <= 4'd0;
      r_scan_cnt   <= '0;
      r_blink_cnt  <= '0;
    end else begin
      r_state      <= state;
      r_state_prev <= r_state;
      r_score      <= score;
      r_scan_cnt   <= r_scan_cnt + 1'b1;
      if (w_hs_live && (r_score > r_high_score)) begin
        r_high_score <= r_score;
      end
      if (w_end_entry) begin
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'b1111;
      r_ssd <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else if (w_blank) begin
      r_an  <= 4'b1111;
      r_ssd <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << w_idx);
      r_ssd <= w_seg;
      r_dp  <= (w_idx != 2'd2);
    end
  end

  assign an  = r_an;
  assign ssd = r_ssd;
  assign dp  = r_dp;

endmodule

// File: tb/tb_score_display_driver.sv
// Self-checking bench: randomized stimulus against a character-level display model.
module tb_score_display_driver;

  localparam logic [6:0] S_START = 7'b0000001, S_L1I = 7'b0000010, S_L1 = 7'b0000100;
  localparam logic [6:0] S_L2I = 7'b0001000, S_L2 = 7'b0010000;
  localparam logic [6:0] S_SUCC = 7'b0100000, S_FAIL = 7'b1000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] score = 4'd0;
  logic [6:0] state = S_START;
  logic [3:0] an;
  logic [6:0] ssd;
  logic       dp;

  int n_cmp = 0;
  int n_err = 0;

  score_display_driver #(
    .REFRESH_BITS (4),
    .BLINK_BITS   (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .score (score),
    .state (state),
    .an    (an),
    .ssd   (ssd),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  // Character shown for a glyph, as active-low segments.
  function automatic logic [6:0] seg_of(input logic [7:0] c);
    logic [6:0] on;
    case (c)
      "0": on = 7'h3F;  "1": on = 7'h06;  "2": on = 7'h5B;  "3": on = 7'h4F;
      "4": on = 7'h66;  "5": on = 7'h6D;  "6": on = 7'h7D;  "7": on = 7'h07;
      "8": on = 7'h7F;  "9": on = 7'h6F;  "A": on = 7'h77;  "B": on = 7'h7C;
      "C": on = 7'h39;  "D": on = 7'h5E;  "E": on = 7'h79;  "F": on = 7'h71;
      "-": on = 7'h40;  "P": on = 7'h73;  "S": on = 7'h6D;
      default: on = 7'h00;
    endcase
    return ~on;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'd0, n};
    return 8'h41 + {4'd0, n} - 8'd10;
  endfunction

  function automatic logic [7:0] char_for(input logic [1:0] d, input logic [6:0] st,
                                          input logic [3:0] sc, input logic [3:0] hi);
    case (d)
      2'd0: return hex_char(sc);
      2'd1: begin
        if (st == S_L1I || st == S_L1) return "1";
        if (st == S_L2I || st == S_L2 || st == S_SUCC) return "2";
        return "-";
      end
      2'd2: return hex_char(hi);
      default: begin
        if (st == S_START) return " ";
        if (st == S_L1I || st == S_L1 || st == S_L2I || st == S_L2) return "P";
        if (st == S_SUCC) return "S";
        if (st == S_FAIL) return "F";
        return "E";
      end
    endcase
  endfunction

  function automatic logic is_end(input logic [6:0] st);
    return (st == S_SUCC) || (st == S_FAIL);
  endfunction

  // Model: what the pins should show after each edge, from the inputs seen one edge earlier.
  logic [3:0] exp_an;
  logic [6:0] exp_ssd;
  logic       exp_dp;
  logic [3:0] m_scan;
  logic [5:0] m_blink;
  logic [3:0] m_high;
  logic [6:0] m_st, m_st_prev;
  logic [3:0] m_score;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_an <= 4'hF; exp_ssd <= 7'h7F; exp_dp <= 1'b1;
      m_scan <= 4'd0; m_blink <= 6'd0; m_high <= 4'd0;
      m_st <= S_START; m_st_prev <= S_START; m_score <= 4'd0;
    end else begin
      if (is_end(m_st) && m_blink >= 6'd32) begin
        exp_an <= 4'hF; exp_ssd <= 7'h7F; exp_dp <= 1'b1;
      end else begin
        exp_an  <= ~(4'b0001 << (m_scan / 4));
        exp_ssd <= seg_of(char_for(2'(m_scan / 4), m_st, m_score, m_high));
        exp_dp  <= (m_scan / 4) != 2;
      end
      if ((m_st == S_L1 || m_st == S_L2 || is_end(m_st)) && m_score > m_high)
        m_high <= m_score;
      m_blink   <= (is_end(m_st) && m_st != m_st_prev) ? 6'd0 : m_blink + 6'd1;
      m_scan    <= m_scan + 4'd1;
      m_st_prev <= m_st;
      m_st      <= state;
      m_score   <= score;
    end
  end

  task automatic test_reset;
    state = S_START; score = 4'd0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({an, ssd, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      n_err++;
      $display("FAIL reset_held: got an=%b ssd=%h dp=%b want an=1111 ssd=7f dp=1", an, ssd, dp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (an !== 4'b1110 || ssd !== seg_of("0")) begin
      n_err++;
      $display("FAIL reset_first_digit: got an=%b ssd=%h want an=1110 ssd=%h",
               an, ssd, seg_of("0"));
    end
  endtask

  task automatic test_l1_scan;
    state = S_L1; score = 4'd5;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, ssd, dp} !== {exp_an, exp_ssd, exp_dp}) begin
        n_err++;
        $display("FAIL l1_scan[%0d]: got %b/%h/%b want %b/%h/%b", i, an, ssd, dp,
                 exp_an, exp_ssd, exp_dp);
      end
      if (i >= 4) begin
        n_cmp++;
        if (dp !== (an != 4'b1011)) begin
          n_err++;
          $display("FAIL l1_dp[%0d]: got dp=%b with an=%b", i, dp, an);
        end
        if (an == 4'b1110 || an == 4'b1011) begin
          n_cmp++;
          if (ssd !== seg_of("5")) begin
            n_err++;
            $display("FAIL l1_digit5[%0d]: got ssd=%h want %h", i, ssd, seg_of("5"));
          end
        end
      end
    end
  endtask

  task automatic test_high_score;
    state = S_L2; score = 4'd9;
    repeat (4) @(negedge clk);
    state = S_START; score = 4'd0;
    repeat (4) @(negedge clk);
    state = S_L1; score = 4'd3;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, ssd, dp} !== {exp_an, exp_ssd, exp_dp}) begin
        n_err++;
        $display("FAIL hs_keep[%0d]: got %b/%h/%b want %b/%h/%b", i, an, ssd, dp,
                 exp_an, exp_ssd, exp_dp);
      end
      if (an == 4'b1011) begin
        n_cmp++;
        if (ssd !== seg_of("9")) begin
          n_err++;
          $display("FAIL hs_d2_9[%0d]: got ssd=%h want %h", i, ssd, seg_of("9"));
        end
      end
    end
    score = 4'd10;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, ssd, dp} !== {exp_an, exp_ssd, exp_dp}) begin
        n_err++;
        $display("FAIL hs_raise[%0d]: got %b/%h/%b want %b/%h/%b", i, an, ssd, dp,
                 exp_an, exp_ssd, exp_dp);
      end
      if (i >= 4 && an == 4'b1011) begin
        n_cmp++;
        if (ssd !== seg_of("A")) begin
          n_err++;
          $display("FAIL hs_d2_A[%0d]: got ssd=%h want %h", i, ssd, seg_of("A"));
        end
      end
    end
  endtask

  task automatic test_blink;
    int blanks = 0;
    state = S_FAIL; score = 4'd12;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, ssd, dp} !== {exp_an, exp_ssd, exp_dp}) begin
        n_err++;
        $display("FAIL blink[%0d]: got %b/%h/%b want %b/%h/%b", i, an, ssd, dp,
                 exp_an, exp_ssd, exp_dp);
      end
      if (i >= 3 && i <= 130 && an == 4'b1111) blanks++;
      if (i >= 3 && i <= 34) begin
        n_cmp++;
        if (an === 4'b1111) begin
          n_err++;
          $display("FAIL blink_visible[%0d]: got an=1111 want one digit active", i);
        end
      end
    end
    n_cmp++;
    if (blanks != 64) begin
      n_err++;
      $display("FAIL blink_duty: got %0d blank cycles want 64", blanks);
    end
  endtask

  task automatic test_illegal;
    state = 7'b0000011; score = 4'd15;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, ssd, dp} !== {exp_an, exp_ssd, exp_dp}) begin
        n_err++;
        $display("FAIL illegal[%0d]: got %b/%h/%b want %b/%h/%b", i, an, ssd, dp,
                 exp_an, exp_ssd, exp_dp);
      end
      if (i >= 4) begin
        n_cmp++;
        if ((an == 4'b0111 && ssd !== seg_of("E")) || (an == 4'b1101 && ssd !== seg_of("-"))
            || (an == 4'b1011 && ssd !== seg_of("C"))) begin
          n_err++;
          $display("FAIL illegal_glyph[%0d]: got an=%b ssd=%h", i, an, ssd);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [6:0] legal [7] = '{S_START, S_L1I, S_L1, S_L2I, S_L2, S_SUCC, S_FAIL};
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 7) == 0) state = 7'($urandom);
      else state = legal[$urandom_range(0, 6)];
      score = 4'($urandom);
      for (int i = 0; i < int'($urandom_range(1, 24)); i++) begin
        @(negedge clk);
        n_cmp++;
        if ({an, ssd, dp} !== {exp_an, exp_ssd, exp_dp}) begin
          n_err++;
          $display("FAIL random[%0d.%0d]: st=%b got %b/%h/%b want %b/%h/%b", s, i, state,
                   an, ssd, dp, exp_an, exp_ssd, exp_dp);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int k;
    rst_n = 1'b0; state = S_START; score = 4'd0;
    @(negedge clk);
    rst_n = 1'b1; state = S_L1; score = 4'd7;
    k = 0;
    while (an !== 4'b1101 && k < 50) begin @(negedge clk); k++; end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (k >= 50 || {an, ssd, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid_scan: got an=%b ssd=%h dp=%b want 1111/7f/1", an, ssd, dp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    state = S_SUCC;
    k = 0;
    while (an !== 4'b1111 && k < 200) begin @(negedge clk); k++; end
    n_cmp++;
    if (k >= 200 || dut.r_high_score !== 4'd7) begin
      n_err++;
      $display("FAIL reset_pre_blink: got high=%h an=%b want high=7 blanked", dut.r_high_score,
               an);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({an, ssd, dp} !== {4'hF, 7'h7F, 1'b1} || dut.r_high_score !== 4'd0) begin
      n_err++;
      $display("FAIL reset_mid_blink: got %b/%h/%b high=%h want 1111/7f/1 high=0", an, ssd, dp,
               dut.r_high_score);
    end
    @(negedge clk);
    rst_n = 1'b1; state = S_L1; score = 4'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, ssd, dp} !== {exp_an, exp_ssd, exp_dp}) begin
        n_err++;
        $display("FAIL after_reset[%0d]: got %b/%h/%b want %b/%h/%b", i, an, ssd, dp,
                 exp_an, exp_ssd, exp_dp);
      end
    end
    n_cmp++;
    if (dut.r_high_score !== 4'd0) begin
      n_err++;
      $display("FAIL high_cleared: got %h want 0", dut.r_high_score);
    end
  endtask

  initial begin
    test_reset();
    test_l1_scan();
    test_high_score();
    test_blink();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
